taylor_stage_2_ctrl: RTL and testbench

Sequencer that drives the control inputs of the Taylor stage-2 Horner datapath: `mul_ss`, `add_ss`, `mul_ss_en` and `add_ss_en`. It accepts one fixed-point operand per transaction on a valid/ready handshake and registers it onto the datapath `IN_B` port. It then steps the datapath through multiply, add (1/6), multiply, add (1/2), and presents the datapath `OUT` as valid on an output handshake. It sits between the exponent range-reduction front end and `taylor_stage_2`, and is the control end of that stage's interface.

---
 rtl/taylor_stage_2_ctrl_if.sv | 35 +++
 rtl/taylor_stage_2_ctrl.sv | 78 +++++++
 tb/tb_taylor_stage_2_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/taylor_stage_2_ctrl_if.sv
// rtl/taylor_stage_2_ctrl_if.sv - handshake and datapath-control bundle for taylor_stage_2_ctrl
//
// Purpose: groups the operand handshake, the result handshake and the
// datapath control lines between the stage-2 sequencer and its neighbours.
// Ports (signals):
//   IN_VALID / IN_READY / IN_DATA[25:0] : operand handshake (3.23 unsigned)
//   OPND[25:0]                          : registered operand to datapath IN_B
//   mul_ss, add_ss                      : datapath multiplier / adder selects
//   mul_ss_en, add_ss_en                : datapath register load strobes
//   OUT_VALID / OUT_READY               : result handshake
//   BUSY                                : sequencer not idle
// Modports: master = sequencer side, slave = environment side.
interface taylor_stage_2_ctrl_if;
  logic        IN_VALID;
  logic        IN_READY;
  logic [25:0] IN_DATA;
  logic [25:0] OPND;
  logic        mul_ss;
  logic        add_ss;
  logic        mul_ss_en;
  logic        add_ss_en;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic        BUSY;

  modport master (
    input  IN_VALID, IN_DATA, OUT_READY,
    output IN_READY, OPND, mul_ss, add_ss, mul_ss_en, add_ss_en, OUT_VALID, BUSY
  );

  modport slave (
    output IN_VALID, IN_DATA, OUT_READY,
    input  IN_READY, OPND, mul_ss, add_ss, mul_ss_en, add_ss_en, OUT_VALID, BUSY
  );
endinterface

// File: rtl/taylor_stage_2_ctrl.sv
// rtl/taylor_stage_2_ctrl.sv - sequencer for the Taylor stage-2 Horner datapath
//
// Purpose: accepts one operand, registers it onto the datapath IN_B port and
// steps the datapath through multiply, add 1/6, multiply, add 1/2, then
// holds the result valid until the consumer takes it.
// Parameters:
//   MUL_WAIT : extra multiplier settle cycles before each mul_ss_en (0..15)
// Ports:
//   CLK   : clock, rising edge
//   RST_N : asynchronous active-low reset
//   bus   : taylor_stage_2_ctrl_if.master (handshakes + datapath controls)
module taylor_stage_2_ctrl #(
  parameter int MUL_WAIT = 0
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  taylor_stage_2_ctrl_if.master        bus
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] MUL0 = 3'd1;
  localparam logic [2:0] ADD0 = 3'd2;
  localparam logic [2:0] MUL1 = 3'd3;
  localparam logic [2:0] ADD1 = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  localparam logic [3:0] WAIT_LAST = 4'(MUL_WAIT);

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [3:0]  cnt;
  logic [25:0] opnd;
  logic        in_mul;
  logic        wait_done;
  logic        accept;

  assign in_mul    = (state == MUL0) || (state == MUL1);
  assign wait_done = (cnt == WAIT_LAST);
  assign accept    = (state == IDLE) && bus.IN_VALID;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.IN_VALID) state_nxt = MUL0;
      MUL0: if (wait_done)    state_nxt = ADD0;
      ADD0:                   state_nxt = MUL1;
      MUL1: if (wait_done)    state_nxt = ADD1;
      ADD1:                   state_nxt = DONE;
      DONE: if (bus.OUT_READY) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // The counter only runs inside a multiply state and is zero everywhere
  // else, so it is already cleared on entry to MUL0 and MUL1.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      cnt   <= 4'd0;
      opnd  <= 26'd0;
    end else begin
      state <= state_nxt;
      cnt   <= (in_mul && !wait_done) ? cnt + 4'd1 : 4'd0;
      if (accept) opnd <= bus.IN_DATA;
    end
  end

  // All outputs decode registered state/counter only.
  assign bus.IN_READY  = (state == IDLE);
  assign bus.BUSY      = (state != IDLE);
  assign bus.OPND      = opnd;
  assign bus.mul_ss    = (state == IDLE) || (state == MUL0);
  assign bus.add_ss    = (state == ADD1) || (state == DONE);
  assign bus.mul_ss_en = in_mul && wait_done;
  assign bus.add_ss_en = (state == ADD0) || (state == ADD1);
  assign bus.OUT_VALID = (state == DONE);

endmodule

// File: tb/tb_taylor_stage_2_ctrl.sv
// tb/tb_taylor_stage_2_ctrl.sv - directed bench for taylor_stage_2_ctrl
module tb_taylor_stage_2_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        sel;          // 0 = MUL_WAIT 0 instance, 1 = MUL_WAIT 3 instance
  logic        in_valid;
  logic        out_ready;
  logic [25:0] in_data;

  int vec = 0;
  int err = 0;

  always #5 CLK = ~CLK;

  taylor_stage_2_ctrl_if if0 ();
  taylor_stage_2_ctrl_if if3 ();

  assign if0.IN_VALID  = in_valid & ~sel;
  assign if3.IN_VALID  = in_valid & sel;
  assign if0.IN_DATA   = in_data;
  assign if3.IN_DATA   = in_data;
  assign if0.OUT_READY = out_ready;
  assign if3.OUT_READY = out_ready;

  taylor_stage_2_ctrl #(.MUL_WAIT(0)) dut0 (.CLK(CLK), .RST_N(RST_N), .bus(if0));
  taylor_stage_2_ctrl #(.MUL_WAIT(3)) dut3 (.CLK(CLK), .RST_N(RST_N), .bus(if3));

  // {IN_READY, BUSY, mul_ss, add_ss, mul_ss_en, add_ss_en, OUT_VALID}
  logic [6:0]  obs0, obs3, obs;
  logic [25:0] obs_opnd;
  assign obs0 = {if0.IN_READY, if0.BUSY, if0.mul_ss, if0.add_ss,
                 if0.mul_ss_en, if0.add_ss_en, if0.OUT_VALID};
  assign obs3 = {if3.IN_READY, if3.BUSY, if3.mul_ss, if3.add_ss,
                 if3.mul_ss_en, if3.add_ss_en, if3.OUT_VALID};
  assign obs      = sel ? obs3 : obs0;
  assign obs_opnd = sel ? if3.OPND : if0.OPND;

  localparam logic [6:0] IDLE_OUT = 7'b1010000;
  localparam logic [6:0] DONE_OUT = 7'b0101001;

  // Caller has applied IN_VALID/IN_DATA at a negedge; the next posedge is
  // the accept edge. Walks cycles 1 .. 5+2w and checks every control line.
  task automatic check_txn(input int w, input logic [25:0] d, input bit keep_valid);
    logic [6:0] exp;
    for (int k = 1; k <= 5 + 2 * w; k++) begin
      @(negedge CLK);
      exp = {1'b0, 1'b1,
             1'(k <= 1 + w),
             1'(k >= 4 + 2 * w),
             1'((k == 1 + w) || (k == 3 + 2 * w)),
             1'((k == 2 + w) || (k == 4 + 2 * w)),
             1'(k == 5 + 2 * w)};
      vec++;
      if (obs !== exp) begin
        err++;
        $display("FAIL txn w=%0d cycle %0d ctl: got %b want %b", w, k, obs, exp);
      end
      vec++;
      if (obs_opnd !== d) begin
        err++;
        $display("FAIL txn w=%0d cycle %0d opnd: got %h want %h", w, k, obs_opnd, d);
      end
      if (k == 1) begin
        in_data = ~d;
        if (!keep_valid) in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    vec++;
    if (obs0 !== IDLE_OUT || if0.OPND !== 26'd0) begin
      err++;
      $display("FAIL reset dut0: got %b/%h want %b/0", obs0, if0.OPND, IDLE_OUT);
    end
    vec++;
    if (obs3 !== IDLE_OUT || if3.OPND !== 26'd0) begin
      err++;
      $display("FAIL reset dut3: got %b/%h want %b/0", obs3, if3.OPND, IDLE_OUT);
    end
    RST_N = 1'b1;
    @(negedge CLK);
    vec++;
    if (obs0 !== IDLE_OUT || obs3 !== IDLE_OUT) begin
      err++;
      $display("FAIL post_reset idle: got %b %b want %b", obs0, obs3, IDLE_OUT);
    end
  endtask

  task automatic test_latency(input bit s, input int w);
    sel = s;
    out_ready = 1'b1;
    in_data = 26'h0800000;
    in_valid = 1'b1;
    check_txn(w, 26'h0800000, 1'b0);
    @(negedge CLK);
    vec++;
    if (obs !== IDLE_OUT) begin
      err++;
      $display("FAIL latency w=%0d return idle: got %b want %b", w, obs, IDLE_OUT);
    end
  endtask

  task automatic test_backpressure;
    sel = 1'b0;
    out_ready = 1'b0;
    in_data = 26'h1234567;
    in_valid = 1'b1;
    check_txn(0, 26'h1234567, 1'b0);
    in_valid = 1'b1;
    in_data = 26'h2abcdef;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      vec++;
      if (obs !== DONE_OUT || obs_opnd !== 26'h1234567) begin
        err++;
        $display("FAIL backpressure hold %0d: got %b/%h want %b/1234567", i, obs, obs_opnd, DONE_OUT);
      end
    end
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
    vec++;
    if (obs !== IDLE_OUT || obs_opnd !== 26'h1234567) begin
      err++;
      $display("FAIL backpressure release idle: got %b/%h want %b/1234567", obs, obs_opnd, IDLE_OUT);
    end
    @(negedge CLK);
    in_valid = 1'b0;
    vec++;
    if (obs !== 7'b0110100 || obs_opnd !== 26'h2abcdef) begin
      err++;
      $display("FAIL backpressure pending accept: got %b/%h want 0110100/2abcdef", obs, obs_opnd);
    end
    out_ready = 1'b1;
    repeat (5) @(negedge CLK);
    vec++;
    if (obs !== IDLE_OUT) begin
      err++;
      $display("FAIL backpressure drain: got %b want %b", obs, IDLE_OUT);
    end
  endtask

  task automatic test_mid_reset;
    sel = 1'b0;
    out_ready = 1'b1;
    in_data = 26'h3000001;
    in_valid = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
    repeat (2) @(negedge CLK);
    vec++;
    if (obs !== 7'b0100100) begin
      err++;
      $display("FAIL midreset cycle3: got %b want 0100100", obs);
    end
    #1 RST_N = 1'b0;
    #1;
    vec++;
    if (obs !== IDLE_OUT || obs_opnd !== 26'd0) begin
      err++;
      $display("FAIL midreset async drop: got %b/%h want %b/0", obs, obs_opnd, IDLE_OUT);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    in_data = 26'h0000abc;
    in_valid = 1'b1;
    check_txn(0, 26'h0000abc, 1'b0);
    @(negedge CLK);
  endtask

  task automatic test_back_to_back;
    logic [25:0] ops [4];
    ops[0] = 26'h0000001;
    ops[1] = 26'h3ffffff;
    ops[2] = 26'h1555555;
    ops[3] = 26'h0800000;
    sel = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int n = 0; n < 4; n++) begin
      vec++;
      if (obs !== IDLE_OUT) begin
        err++;
        $display("FAIL back_to_back op %0d not idle at accept slot: got %b", n, obs);
      end
      in_data = ops[n];
      check_txn(0, ops[n], 1'b1);
      @(negedge CLK);
    end
    in_valid = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    sel = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_data = 26'd0;
    test_reset();
    test_latency(1'b0, 0);
    test_latency(1'b1, 3);
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
